meas_frame_tx: RTL and testbench

- Upstream neighbour of the AXI-stream data memory.
- Accepts 32-bit frequency-measurement results from the measurement core and buffers them in a small FIFO.
- Serialises each result into a 4-beat, byte-wide AXI-stream frame tagged with the destination component ID.
- The frame format matches the memory's 4-beat frame slave: ID check, tlast on the final beat.

---
 rtl/freq_meter_pkg.sv | 14 +
 rtl/axi_if.sv | 11 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/meas_frame_tx.sv | 117 +++++++++++
 tb/tb_meas_frame_tx.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/freq_meter_pkg.sv
// Shared constants and types for the frequency-meter datapath.
package freq_meter_pkg;

  // Bytes carried by one measurement frame on the byte-wide stream.
  localparam int BYTES_PER_FRAME = 4;
  localparam int BEAT_W          = $clog2(BYTES_PER_FRAME);

  // Component IDs carried on tid.
  localparam logic [7:0] MEAS_CORE_ID = 8'h31;
  localparam logic [7:0] DATA_MEM_ID  = 8'h7A;

  typedef enum logic {IDLE, SEND} tx_state_t;

endpackage

// File: rtl/axi_if.sv
// Byte-wide AXI-stream link with a component-ID side channel.
interface axi_if;
  logic [7:0] tdata;
  logic [7:0] tid;
  logic       tvalid;
  logic       tready;
  logic       tlast;

  modport master (output tdata, tid, tvalid, tlast, input tready);
  modport slave  (input tdata, tid, tvalid, tlast, output tready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pushes into a full FIFO are ignored.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Flags decode the registered count, so they never see this cycle's push/pop.
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rd_ptr_q];

  // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of two).
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  // Control state; reset empties the FIFO, storage contents are don't-care.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/meas_frame_tx.sv
// Buffers 32-bit measurement results and sends each as a 4-beat MSB-first
// byte frame tagged with DEST_ID; tlast marks the final beat.
module meas_frame_tx
  import freq_meter_pkg::*;
#(
  parameter logic [7:0] DEST_ID    = DATA_MEM_ID,
  parameter int         FIFO_DEPTH = 4,
  parameter int         CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          meas_data,
  input  logic                 meas_valid,
  axi_if.master                axi,
  output logic [CNT_WIDTH-1:0] ovf_cnt,
  output logic                 busy
);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BYTES_PER_FRAME - 1);

  logic        fifo_full, fifo_empty, fifo_pop;
  logic [31:0] fifo_dout;

  tx_state_t            state_q, state_d;
  logic [31:0]          shreg_q, shreg_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
  logic [CNT_WIDTH-1:0] ovf_q, ovf_d;
  logic                 hs;

  sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (meas_valid),
    .pop   (fifo_pop),
    .din   (meas_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign hs = tvalid_q && axi.tready;

  // Frame sequencing: load a result, shift one byte out per handshake,
  // chain straight into the next result when one is already waiting.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    beat_d   = beat_q;
    tvalid_d = tvalid_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = fifo_dout;
          beat_d   = '0;
          tvalid_d = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (beat_q == LAST_BEAT) begin
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shreg_d  = fifo_dout;
              beat_d   = '0;
            end else begin
              tvalid_d = 1'b0;
              beat_d   = '0;
              state_d  = IDLE;
            end
          end else begin
            shreg_d = {shreg_q[23:0], 8'h00};
            beat_d  = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    tlast_d = tvalid_d && (beat_d == LAST_BEAT);
  end

  // Dropped-result counter, saturating so it never wraps back to a small value.
  always_comb begin
    ovf_d = ovf_q;
    if (meas_valid && fifo_full && (ovf_q != '1)) ovf_d = ovf_q + CNT_WIDTH'(1);
  end

  // Sequencer and counter registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      beat_q   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      beat_q   <= beat_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      ovf_q    <= ovf_d;
    end
  end

  assign axi.tdata  = shreg_q[31:24];
  assign axi.tid    = DEST_ID;
  assign axi.tvalid = tvalid_q;
  assign axi.tlast  = tlast_q;
  assign ovf_cnt    = ovf_q;
  assign busy       = !fifo_empty || (state_q == SEND);

endmodule

// File: tb/tb_meas_frame_tx.sv
// Scoreboard bench for meas_frame_tx: stimulus queues the expected beats of
// every accepted result, a negedge monitor pops and compares each handshake.
module tb_meas_frame_tx;
  localparam logic [7:0] DEST  = 8'h7A;
  localparam int         DEPTH = 4;
  localparam int         CW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   meas_data;
  logic          meas_valid;
  logic [CW-1:0] ovf_cnt;
  logic          busy;

  axi_if axi();

  meas_frame_tx #(.DEST_ID(DEST), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .meas_data  (meas_data),
    .meas_valid (meas_valid),
    .axi        (axi),
    .ovf_cnt    (ovf_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  beat_t   exp_q[$];
  int      hs_edges[$];
  int      cyc = 0;
  int      n_chk = 0;
  int      n_pass = 0;
  int      frames_done = 0;
  int      n_acc = 0;
  int      last_cap = 0;
  logic [CW-1:0] ovf_exp = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every handshake is compared with the head of the expected queue;
  // while stalled, the presented beat must not change.
  initial begin
    beat_t      e;
    bit         stall_pend;
    logic [9:0] stall_snap;
    stall_pend = 0;
    stall_snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        stall_pend = 0;
      end else begin
        if (stall_pend)
          chk("hold_stable", {axi.tdata, axi.tlast, axi.tvalid}, stall_snap);
        if (axi.tvalid && axi.tready) begin
          if (exp_q.size() == 0) chk("unexpected_beat", {56'd0, axi.tdata}, 64'hFFFF);
          else begin
            e = exp_q.pop_front();
            chk("beat", {axi.tdata, axi.tid, axi.tlast}, {e.data, DEST, e.last});
          end
          hs_edges.push_back(cyc + 1);
          if (axi.tlast) frames_done++;
          stall_pend = 0;
        end else if (axi.tvalid) begin
          stall_pend = 1;
          stall_snap = {axi.tdata, axi.tlast, axi.tvalid};
        end else stall_pend = 0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Model: an accepted result becomes four MSB-first beats, tlast on the fourth;
  // a rejected one bumps the saturating drop count.
  task automatic strobe(input logic [31:0] v, input bit accept);
    meas_data  = v;
    meas_valid = 1'b1;
    @(posedge clk);
    #1;
    meas_valid = 1'b0;
    last_cap   = cyc;
    if (accept) begin
      for (int b = 0; b < 4; b++) exp_q.push_back({v[31-8*b -: 8], b == 3});
      n_acc++;
    end else if (ovf_exp != '1) ovf_exp = ovf_exp + 1'b1;
  endtask

  task automatic drain(input int bound);
    int k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      cycles(1);
      k++;
    end
    chk("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycles(2);
    rst = 1'b0;
    ovf_exp = '0;
    cycles(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, acc_base, fd_base, k;
    rst = 1'b1;
    meas_valid = 1'b0;
    meas_data = '0;
    axi.tready = 1'b0;
    #1;
    cycles(2);
    chk("reset_state", {axi.tvalid, axi.tlast, axi.tdata, axi.tid, ovf_cnt, busy},
        {1'b0, 1'b0, 8'h00, DEST, 8'h00, 1'b0});
    rst = 1'b0;
    cycles(1);

    // Single result: latency and ordering.
    axi.tready = 1'b1;
    base = hs_edges.size();
    strobe(32'hDEADBEEF, 1);
    chk("busy_after_capture", busy, 1);
    drain(20);
    cycles(2);
    chk("single_first_beat_edge", hs_edges[base] - last_cap, 2);
    chk("single_last_beat_edge", hs_edges[base+3] - last_cap, 5);
    chk("busy_after_frame", busy, 0);

    // Backpressure on beat 1.
    strobe(32'hDEADBEEF, 1);
    cycles(2);
    axi.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycles(1);
      chk("stall_beat1", {axi.tvalid, axi.tdata, axi.tlast}, {1'b1, 8'hAD, 1'b0});
    end
    axi.tready = 1'b1;
    drain(20);

    // Back-to-back frames.
    cycles(2);
    base = hs_edges.size();
    strobe(32'h01020304, 1);
    strobe(32'h05060708, 1);
    drain(30);
    chk("b2b_beat_count", hs_edges.size() - base, 8);
    chk("b2b_no_gap", hs_edges[base+7] - hs_edges[base], 7);

    // Overflow: one result parked on the stalled link, then 1..6 with room for four.
    cycles(2);
    axi.tready = 1'b0;
    strobe(32'hA0A1A2A3, 1);
    cycles(2);
    for (int i = 1; i <= 6; i++) strobe(i, i <= DEPTH);
    cycles(1);
    chk("ovf_count", ovf_cnt, ovf_exp);
    chk("ovf_is_two", ovf_exp, 2);
    chk("busy_stalled", busy, 1);
    axi.tready = 1'b1;
    drain(60);
    chk("ovf_hold_after_drain", ovf_cnt, ovf_exp);

    // Saturation: five consecutive strobes fit (one loads straight out), the rest drop.
    do_reset();
    axi.tready = 1'b0;
    for (int i = 0; i < 305 + 5 + 5; i++) begin
      strobe($urandom, i < 5);
      if (i == 5 + 253) chk("ovf_254", ovf_cnt, ovf_exp);
    end
    cycles(1);
    chk("ovf_saturated", ovf_cnt, 8'hFF);
    chk("ovf_model", ovf_cnt, ovf_exp);
    axi.tready = 1'b1;
    drain(80);

    // Reset during beat 2.
    do_reset();
    chk("ovf_cleared", ovf_cnt, 0);
    strobe(32'h11223344, 1);
    cycles(3);
    chk("pre_reset_beat2", {axi.tvalid, axi.tdata}, {1'b1, 8'h33});
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_tvalid", {axi.tvalid, axi.tlast, busy}, 3'b000);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ovf_exp = '0;
    base = hs_edges.size();
    cycles(20);
    chk("no_frame_after_reset", hs_edges.size() - base, 0);
    strobe(32'h55667788, 1);
    drain(20);
    chk("post_reset_frame_beats", hs_edges.size() - base, 4);
    chk("post_reset_frame_span", hs_edges[base+3] - hs_edges[base], 3);

    // Random traffic with random backpressure, kept below FIFO capacity.
    cycles(2);
    acc_base = n_acc;
    fd_base  = frames_done;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          k = 0;
          while (((n_acc - acc_base) - (frames_done - fd_base)) >= DEPTH && k < 200) begin
            cycles(1);
            k++;
          end
          if (k >= 200) chk("gate_timeout", k, 0);
          cycles($urandom_range(0, 3));
          strobe($urandom, 1);
        end
      end
      begin
        repeat (600) begin
          axi.tready = 1'($urandom_range(0, 1));
          cycles(1);
        end
        axi.tready = 1'b1;
      end
    join
    drain(200);
    chk("random_frames", frames_done - fd_base, 60);
    chk("random_no_ovf", ovf_cnt, ovf_exp);
    cycles(2);
    chk("busy_final", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
